// File: rtl/led_ctrl_pkg.sv
// Purpose: shared LED mode encoding and mode-advance order for the LED controller.
// Latency: pure types and combinational helpers, no state.
// Backpressure: none.
package led_ctrl_pkg;

  typedef enum logic [1:0] {
    OFF        = 2'd0,
    ON         = 2'd1,
    BLINK_SLOW = 2'd2,
    BLINK_FAST = 2'd3
  } mode_t;

  // Button-press sequence: OFF -> ON -> BLINK_SLOW -> BLINK_FAST -> OFF.
  function automatic mode_t next_mode(mode_t m);
    mode_t r;
    unique case (m)
      OFF:        r = ON;
      ON:         r = BLINK_SLOW;
      BLINK_SLOW: r = BLINK_FAST;
      BLINK_FAST: r = OFF;
      default:    r = OFF;
    endcase
    return r;
  endfunction

  // True for the two modes that use the blink timebase.
  function automatic logic is_blink(mode_t m);
    return (m == BLINK_SLOW) || (m == BLINK_FAST);
  endfunction

endpackage

// File: rtl/led_mode_controller_if.sv
// Purpose: board-side pins of the LED controller (raw button in, LED and mode out).
// Latency: wires only.
// Backpressure: none; level signals.
interface led_mode_controller_if;
  logic       button;
  logic       led;
  logic [1:0] mode;

  // Board / stimulus side drives the button and observes the LED.
  modport master (output button, input led, input mode);
  // Controller side.
  modport slave  (input button, output led, output mode);
endinterface

// File: rtl/button_debouncer.sv
// Purpose: two-flop synchroniser, counter debounce and rising-edge press detect.
// Latency: a level change is accepted DEBOUNCE_CYCLES+2 edges after it reaches button_raw.
// Backpressure: none; press is a single-cycle strobe on the accepting edge.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 25
) (
  input  logic clk,
  input  logic reset,
  input  logic button_raw,
  output logic btn_db,
  output logic press
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q;
  logic             s2_q;
  logic             db_q;
  logic             db_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Bring the asynchronous button into the clk domain.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= button_raw;
      s2_q <= s1_q;
    end
  end

  // Count consecutive disagreeing cycles; any bounce back restarts the count.
  always_comb begin
    cnt_d = cnt_q;
    db_d  = db_q;
    if (s2_q == db_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      db_d  = s2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Debounced level and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      db_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      db_q  <= db_d;
      cnt_q <= cnt_d;
    end
  end

  // Press is combinational so the consumer updates on the same edge btn_db rises.
  always_comb begin
    btn_db = db_q;
    press  = ~db_q & db_d;
  end

endmodule

// File: rtl/led_mode_controller.sv
// Purpose: mode FSM advanced by debounced presses, plus blink timebase and LED decode.
// Latency: mode changes on the edge the debounced button rises; led decodes registered state.
// Backpressure: none; every press is acted on.
module led_mode_controller
  import led_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SLOW_HALF       = 25000000,
  parameter int FAST_HALF       = 6250000,
  parameter int CNT_W           = 25
) (
  input  logic                  clk,
  input  logic                  reset,
  led_mode_controller_if.slave  io
);

  localparam logic [CNT_W-1:0] SLOW_LAST = CNT_W'(SLOW_HALF - 1);
  localparam logic [CNT_W-1:0] FAST_LAST = CNT_W'(FAST_HALF - 1);

  mode_t            mode_q;
  mode_t            mode_d;
  logic [CNT_W-1:0] blink_cnt_q;
  logic [CNT_W-1:0] blink_cnt_d;
  logic             phase_q;
  logic             phase_d;
  logic [CNT_W-1:0] half_last;
  logic             press;
  logic             btn_db;
  logic             btn_db_unused;

  button_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_debounce (
    .clk        (clk),
    .reset      (reset),
    .button_raw (io.button),
    .btn_db     (btn_db),
    .press      (press)
  );

  // The debounced level itself is not needed here; only the press strobe is.
  assign btn_db_unused = btn_db;

  // Mode state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q <= OFF;
    end else begin
      mode_q <= mode_d;
    end
  end

  // Advance one step per press; holding the button yields a single press.
  always_comb begin
    mode_d = mode_q;
    if (press) begin
      mode_d = next_mode(mode_q);
    end
  end

  // Blink half-period select and counter/phase next state; a press beats a wrap.
  always_comb begin
    half_last   = (mode_q == BLINK_FAST) ? FAST_LAST : SLOW_LAST;
    blink_cnt_d = '0;
    phase_d     = 1'b0;
    if (press) begin
      blink_cnt_d = '0;
      phase_d     = is_blink(mode_d);
    end else if (is_blink(mode_q)) begin
      if (blink_cnt_q == half_last) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
        phase_d     = phase_q;
      end
    end
  end

  // Blink timebase registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  // Output decode straight from registered state.
  always_comb begin
    io.led  = (mode_q == ON) | (is_blink(mode_q) & phase_q);
    io.mode = mode_q;
  end

endmodule

// File: tb/tb_led_mode_controller.sv
// Purpose: directed self-checking bench for led_mode_controller with small parameters.
// Latency: samples outputs 1 time unit after each rising edge.
// Backpressure: none.
module tb_led_mode_controller;
  import led_ctrl_pkg::*;

  typedef struct packed {
    logic [1:0] mode;
    logic       led;
  } exp_t;

  logic  clk = 1'b0;
  logic  reset;
  int    passed = 0;
  int    total  = 0;
  exp_t  exp_q[$];
  string tag_q[$];

  always #5 clk = ~clk;

  led_mode_controller_if io();

  led_mode_controller #(
    .DEBOUNCE_CYCLES (4),
    .SLOW_HALF       (8),
    .FAST_HALF       (2),
    .CNT_W           (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .io    (io)
  );

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input logic [1:0] m, input logic l);
    exp_t e;
    e.mode = m;
    e.led  = l;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  // Advance one edge and compare DUT outputs against the oldest expectation.
  task automatic step_pop();
    exp_t  e;
    string t;
    tick();
    if (exp_q.size() == 0) begin
      total++;
      $error("FAIL scoreboard_empty: observed 0 entries expected 1");
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check({t, "_mode"}, {2'b00, io.mode}, {2'b00, e.mode});
      check({t, "_led"},  {3'b000, io.led}, {3'b000, e.led});
    end
  endtask

  task automatic run(input string tag, input int n, input logic [1:0] m, input logic l);
    for (int i = 0; i < n; i++) push(tag, m, l);
    for (int i = 0; i < n; i++) step_pop();
  endtask

  function automatic logic slow_led(input int i);
    return ((i / 8) % 2) == 0;
  endfunction

  function automatic logic fast_led(input int i);
    return ((i / 2) % 2) == 0;
  endfunction

  initial begin
    reset     = 1'b1;
    io.button = 1'b1;

    // Reset with button held: one press counted six edges after release.
    run("rst_hold", 3, 2'd0, 1'b0);
    reset = 1'b0;
    run("rel_wait", 5, 2'd0, 1'b0);
    run("rel_press", 1, 2'd1, 1'b1);
    io.button = 1'b0;
    run("rel_release", 10, 2'd1, 1'b1);

    // Back to OFF, then a clean press held 50 cycles.
    reset = 1'b1;
    run("rst2", 2, 2'd0, 1'b0);
    reset = 1'b0;
    run("idle", 3, 2'd0, 1'b0);
    io.button = 1'b1;
    run("press_wait", 5, 2'd0, 1'b0);
    run("press_edge", 1, 2'd1, 1'b1);
    run("hold", 50, 2'd1, 1'b1);
    io.button = 1'b0;
    run("release", 10, 2'd1, 1'b1);

    // Bounce rejection: 3-cycle pulses never reach acceptance.
    reset = 1'b1;
    run("rst3", 1, 2'd0, 1'b0);
    reset = 1'b0;
    run("idle2", 2, 2'd0, 1'b0);
    for (int r = 0; r < 5; r++) begin
      io.button = 1'b1;
      run("bounce_hi", 3, 2'd0, 1'b0);
      io.button = 1'b0;
      run("bounce_lo", 3, 2'd0, 1'b0);
    end
    run("bounce_end", 6, 2'd0, 1'b0);

    // Press to ON, then to BLINK_SLOW.
    io.button = 1'b1;
    run("p1_wait", 5, 2'd0, 1'b0);
    run("p1_edge", 1, 2'd1, 1'b1);
    io.button = 1'b0;
    run("p1_rel", 6, 2'd1, 1'b1);
    io.button = 1'b1;
    run("p2_wait", 5, 2'd1, 1'b1);
    run("slow_entry", 1, 2'd2, 1'b1);
    io.button = 1'b0;
    for (int i = 1; i < 24; i++) push("slow", 2'd2, slow_led(i));
    for (int i = 1; i < 24; i++) step_pop();

    // Third press to BLINK_FAST.
    io.button = 1'b1;
    for (int i = 24; i < 29; i++) push("slow_tail", 2'd2, slow_led(i));
    push("fast_entry", 2'd3, 1'b1);
    for (int i = 24; i < 30; i++) step_pop();
    io.button = 1'b0;
    for (int j = 1; j < 12; j++) push("fast", 2'd3, fast_led(j));
    for (int j = 1; j < 12; j++) step_pop();

    // Fourth press wraps to OFF with the timebase cleared.
    io.button = 1'b1;
    for (int j = 12; j < 17; j++) push("fast_tail", 2'd3, fast_led(j));
    push("wrap_off", 2'd0, 1'b0);
    for (int j = 12; j < 18; j++) step_pop();
    check("wrap_blink_cnt", 4'(dut.blink_cnt_q), 4'd0);
    check("wrap_phase", {3'b000, dut.phase_q}, 4'd0);
    io.button = 1'b0;
    run("off_rel", 6, 2'd0, 1'b0);

    // Collision: press lands on the third slow wrap (which would turn the LED off).
    io.button = 1'b1;
    run("c1_wait", 5, 2'd0, 1'b0);
    run("c1_edge", 1, 2'd1, 1'b1);
    io.button = 1'b0;
    run("c1_rel", 6, 2'd1, 1'b1);
    io.button = 1'b1;
    run("c2_wait", 5, 2'd1, 1'b1);
    run("c_slow_entry", 1, 2'd2, 1'b1);
    io.button = 1'b0;
    for (int i = 1; i < 19; i++) push("c_slow", 2'd2, slow_led(i));
    for (int i = 1; i < 19; i++) step_pop();
    io.button = 1'b1;
    for (int i = 19; i < 24; i++) push("c_slow_tail", 2'd2, slow_led(i));
    push("c_fast_entry", 2'd3, 1'b1);
    for (int j = 1; j < 6; j++) push("c_fast", 2'd3, fast_led(j));
    for (int i = 0; i < 11; i++) step_pop();
    io.button = 1'b0;

    // Reset mid-blink.
    reset = 1'b1;
    run("rst_mid", 1, 2'd0, 1'b0);
    check("rst_mid_blink_cnt", 4'(dut.blink_cnt_q), 4'd0);
    reset = 1'b0;
    run("post_rst", 4, 2'd0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
